// File: rtl/peripheral_mpi_buffer_endpoint.sv
// Single-channel MPI message buffer endpoint.
// The bus side writes length-prefixed packets into an egress FIFO that is only
// exposed to the NoC once a whole packet has been written (store-and-forward).
// Flits arriving from the NoC land in an ingress FIFO and are popped by bus reads.
// irq is raised while complete received packets are pending and irq_en is set.

module peripheral_mpi_buffer_endpoint #(
  parameter int NOC_FLIT_WIDTH = 32,
  parameter int SIZE           = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic [NOC_FLIT_WIDTH-1:0] noc_out_flit,
  output logic                      noc_out_last,
  output logic                      noc_out_valid,
  input  logic                      noc_out_ready,
  input  logic [NOC_FLIT_WIDTH-1:0] noc_in_flit,
  input  logic                      noc_in_last,
  input  logic                      noc_in_valid,
  output logic                      noc_in_ready,
  input  logic [31:0]               bus_addr,
  input  logic                      bus_we,
  input  logic                      bus_en,
  input  logic [31:0]               bus_data_in,
  output logic [31:0]               bus_data_out,
  output logic                      bus_ack,
  output logic                      bus_err,
  output logic                      irq
);

  localparam int AW = $clog2(SIZE);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH = PW'(SIZE);
  localparam logic [PW-1:0] ONE   = PW'(1);

  localparam logic [2:0] REG_DATA   = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd1;
  localparam logic [2:0] REG_IRQEN  = 3'd2;
  localparam logic [2:0] REG_RXPKTS = 3'd3;

  typedef enum logic {
    S_IDLE,
    S_DATA
  } egState_t;

  // Storage: each entry carries the last-flit marker above the data bits
  logic [NOC_FLIT_WIDTH:0] r_egMem [SIZE];
  logic [NOC_FLIT_WIDTH:0] r_inMem [SIZE];

  logic [PW-1:0] r_egWr;
  logic [PW-1:0] r_egRd;
  logic [PW-1:0] r_egCommit;
  logic [PW-1:0] r_egRemain;
  egState_t      r_state;

  logic [PW-1:0] r_inWr;
  logic [PW-1:0] r_inRd;
  logic [PW-1:0] r_rxPkts;
  logic          r_lastRd;

  logic          r_irqEn;
  logic          r_irq;
  logic          r_ack;
  logic          r_err;
  logic [31:0]   r_rdata;

  logic                    w_egValid;
  logic                    w_egPop;
  logic                    w_egFull;
  logic [PW-1:0]           w_egRdNext;
  logic [PW-1:0]           w_egFree;
  logic                    w_egEmpty;
  logic [NOC_FLIT_WIDTH:0] w_egHead;
  logic                    w_inFull;
  logic                    w_inEmpty;
  logic                    w_inPush;
  logic [NOC_FLIT_WIDTH:0] w_inHead;
  logic                    w_req;
  logic [2:0]              w_regSel;
  logic                    w_dataWrite;
  logic                    w_stall;
  logic                    w_sendWr;
  logic                    w_lenOk;
  logic                    w_rxPop;
  logic                    w_rxInc;
  logic                    w_rxDec;
  logic [7:0]              w_freeField;
  logic [31:0]             w_status;
  logic                    w_unused;

  // Only address bits [4:2] select a register
  assign w_unused = ^{bus_addr[31:5], bus_addr[1:0]};

  // Egress side: only committed flits are ever presented to the NoC
  assign w_egValid  = (r_egRd != r_egCommit);
  assign w_egPop    = w_egValid & noc_out_ready;
  assign w_egFull   = ((r_egWr - r_egRd) == DEPTH);
  assign w_egRdNext = r_egRd + PW'(w_egPop);
  assign w_egFree   = DEPTH - (r_egWr - w_egRdNext);
  assign w_egEmpty  = (r_egWr == w_egRdNext);
  assign w_egHead   = r_egMem[r_egRd[AW-1:0]];

  assign noc_out_valid = w_egValid;
  assign noc_out_flit  = w_egValid ? w_egHead[NOC_FLIT_WIDTH-1:0] : '0;
  assign noc_out_last  = w_egValid & w_egHead[NOC_FLIT_WIDTH];

  // Ingress side
  assign w_inFull     = ((r_inWr - r_inRd) == DEPTH);
  assign w_inEmpty    = (r_inWr == r_inRd);
  assign noc_in_ready = ~w_inFull & ~rst;
  assign w_inPush     = noc_in_valid & noc_in_ready;
  assign w_inHead     = r_inMem[r_inRd[AW-1:0]];

  // Bus request decode; a request is only taken while no ack is outstanding
  assign w_req       = bus_en & ~r_ack;
  assign w_regSel    = bus_addr[4:2];
  assign w_dataWrite = w_req & bus_we & (w_regSel == REG_DATA) & (r_state == S_DATA);
  assign w_stall     = w_dataWrite & w_egFull;
  assign w_sendWr    = w_dataWrite & ~w_egFull;
  assign w_lenOk     = (bus_data_in != 32'd0) && (bus_data_in <= 32'(SIZE));
  assign w_rxPop     = w_req & ~bus_we & (w_regSel == REG_DATA) & ~w_inEmpty;
  assign w_rxInc     = w_inPush & noc_in_last;
  assign w_rxDec     = w_rxPop & w_inHead[NOC_FLIT_WIDTH];

  assign w_freeField = 8'(w_egFree);
  assign w_status    = {16'h0000, w_freeField, 4'h0, r_lastRd, w_egEmpty,
                        (r_state == S_IDLE), (r_rxPkts != '0)};

  assign bus_ack      = r_ack;
  assign bus_err      = r_err;
  assign bus_data_out = r_rdata;
  assign irq          = r_irq;

  // FIFO storage writes; contents need no reset because pointers guard them
  always_ff @(posedge clk) begin
    if (w_sendWr) begin
      r_egMem[r_egWr[AW-1:0]] <= {(r_egRemain == ONE), bus_data_in};
    end
    if (w_inPush) begin
      r_inMem[r_inWr[AW-1:0]] <= {noc_in_last, noc_in_flit};
    end
  end

  // Egress packet assembly FSM and egress pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_egWr     <= '0;
      r_egRd     <= '0;
      r_egCommit <= '0;
      r_egRemain <= '0;
    end else begin
      if (w_egPop) begin
        r_egRd <= r_egRd + ONE;
      end
      case (r_state)
        S_IDLE: begin
          if (w_req && bus_we && (w_regSel == REG_DATA) && w_lenOk) begin
            r_egRemain <= bus_data_in[PW-1:0];
            r_state    <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_sendWr) begin
            r_egWr     <= r_egWr + ONE;
            r_egRemain <= r_egRemain - ONE;
            if (r_egRemain == ONE) begin
              r_egCommit <= r_egWr + ONE;
              r_state    <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Ingress pointers, pending packet count and last-popped marker
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inWr   <= '0;
      r_inRd   <= '0;
      r_rxPkts <= '0;
      r_lastRd <= 1'b0;
    end else begin
      if (w_inPush) begin
        r_inWr <= r_inWr + ONE;
      end
      if (w_rxPop) begin
        r_inRd   <= r_inRd + ONE;
        r_lastRd <= w_inHead[NOC_FLIT_WIDTH];
      end
      case ({w_rxInc, w_rxDec})
        2'b10:   r_rxPkts <= r_rxPkts + ONE;
        2'b01:   r_rxPkts <= r_rxPkts - ONE;
        default: r_rxPkts <= r_rxPkts;
      endcase
    end
  end

  // Registered bus response; a stalled send write waits without acking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
      r_irqEn <= 1'b0;
    end else begin
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
      if (w_req && !w_stall) begin
        r_ack <= 1'b1;
        case (w_regSel)
          REG_DATA: begin
            if (bus_we) begin
              r_err <= (r_state == S_IDLE) && !w_lenOk;
            end else if (w_inEmpty) begin
              r_err <= 1'b1;
            end else begin
              r_rdata <= w_inHead[NOC_FLIT_WIDTH-1:0];
            end
          end
          REG_STATUS: begin
            if (bus_we) r_err <= 1'b1;
            else        r_rdata <= w_status;
          end
          REG_IRQEN: begin
            if (bus_we) r_irqEn <= bus_data_in[0];
            else        r_rdata <= {31'd0, r_irqEn};
          end
          REG_RXPKTS: begin
            if (bus_we) r_err <= 1'b1;
            else        r_rdata <= 32'(r_rxPkts);
          end
          default: r_err <= 1'b1;
        endcase
      end
    end
  end

  // Level interrupt, one cycle behind the pending-packet condition
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= r_irqEn & (r_rxPkts != '0);
    end
  end

endmodule

// File: tb/tb_peripheral_mpi_buffer_endpoint.sv
// Bench for the MPI buffer endpoint: register table, directed packet corner
// cases, then randomized bus/NoC traffic against a queue-based model.

module tb_peripheral_mpi_buffer_endpoint;

  localparam int SIZE = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] noc_out_flit;
  logic        noc_out_last;
  logic        noc_out_valid;
  logic        noc_out_ready = 1'b0;
  logic [31:0] noc_in_flit = '0;
  logic        noc_in_last = 1'b0;
  logic        noc_in_valid = 1'b0;
  logic        noc_in_ready;
  logic [31:0] bus_addr = '0;
  logic        bus_we = 1'b0;
  logic        bus_en = 1'b0;
  logic [31:0] bus_data_in = '0;
  logic [31:0] bus_data_out;
  logic        bus_ack;
  logic        bus_err;
  logic        irq;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit done  = 0;

  typedef struct {
    logic        we;
    logic [2:0]  regIdx;
    logic [31:0] wdata;
    logic [31:0] expData;
    logic        expErr;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        last;
    int          land;
  } inEnt_t;

  localparam int NVEC = 15;
  vec_t        vecs[NVEC];
  logic [32:0] egQ[$];
  inEnt_t      inQ[$];

  peripheral_mpi_buffer_endpoint #(
    .NOC_FLIT_WIDTH(32),
    .SIZE(SIZE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .noc_out_flit(noc_out_flit),
    .noc_out_last(noc_out_last),
    .noc_out_valid(noc_out_valid),
    .noc_out_ready(noc_out_ready),
    .noc_in_flit(noc_in_flit),
    .noc_in_last(noc_in_last),
    .noc_in_valid(noc_in_valid),
    .noc_in_ready(noc_in_ready),
    .bus_addr(bus_addr),
    .bus_we(bus_we),
    .bus_en(bus_en),
    .bus_data_in(bus_data_in),
    .bus_data_out(bus_data_out),
    .bus_ack(bus_ack),
    .bus_err(bus_err),
    .irq(irq)
  );

  always #5 clk = ~clk;

  // Edge counter used to timestamp ingress flit arrival against bus reads
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [32:0] act, input logic [32:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // One bus transaction; the leading negedge guarantees the previous ack has cleared
  task automatic applyStimulus(input logic we, input logic [2:0] regIdx, input logic [31:0] wdata,
                               output logic [31:0] rdata, output logic err, output int driveCyc);
    logic [31:0] a;
    bit got;
    @(negedge clk);
    a = $urandom();
    a[4:2] = regIdx;
    bus_addr    = a;
    bus_we      = we;
    bus_data_in = wdata;
    bus_en      = 1'b1;
    driveCyc    = cyc;
    got   = 0;
    rdata = '0;
    err   = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (bus_ack) begin
        got   = 1;
        rdata = bus_data_out;
        err   = bus_err;
      end
    end
    bus_en = 1'b0;
    if (!got) begin
      total++;
      bad++;
      $display("[TB] FAIL ackTimeout actual=no-ack required=ack");
    end
  endtask

  task automatic busWrite(input string name, input logic [2:0] regIdx, input logic [31:0] d, input logic expErr);
    logic [31:0] rd;
    logic er;
    int dc;
    applyStimulus(1'b1, regIdx, d, rd, er, dc);
    checkOutput(name, er, expErr);
  endtask

  task automatic busRead(input string name, input logic [2:0] regIdx, input logic [31:0] expData, input logic expErr);
    logic [31:0] rd;
    logic er;
    int dc;
    applyStimulus(1'b0, regIdx, 32'h0, rd, er, dc);
    checkOutput(name, {er, rd}, {expErr, expData});
  endtask

  task automatic injectFlit(input logic [31:0] d, input logic last);
    @(negedge clk);
    noc_in_flit  = d;
    noc_in_last  = last;
    noc_in_valid = 1'b1;
    checkOutput("injReady", noc_in_ready, 1'b1);
    @(negedge clk);
    noc_in_valid = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst           = 1'b1;
    bus_en        = 1'b0;
    noc_out_ready = 1'b0;
    noc_in_valid  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [32:0] got[$];
    logic [31:0] rd;
    logic        er;
    int          dc;
    int          ackDelay;
    bit          acked;

    vecs[0]  = '{1'b0, 3'd1, 32'h0,  32'h0000_1006, 1'b0};
    vecs[1]  = '{1'b0, 3'd2, 32'h0,  32'h0,         1'b0};
    vecs[2]  = '{1'b1, 3'd2, 32'h1,  32'h0,         1'b0};
    vecs[3]  = '{1'b0, 3'd2, 32'h0,  32'h1,         1'b0};
    vecs[4]  = '{1'b1, 3'd2, 32'h0,  32'h0,         1'b0};
    vecs[5]  = '{1'b0, 3'd3, 32'h0,  32'h0,         1'b0};
    vecs[6]  = '{1'b0, 3'd0, 32'h0,  32'h0,         1'b1};
    vecs[7]  = '{1'b1, 3'd1, 32'h5,  32'h0,         1'b1};
    vecs[8]  = '{1'b1, 3'd3, 32'h5,  32'h0,         1'b1};
    vecs[9]  = '{1'b0, 3'd5, 32'h0,  32'h0,         1'b1};
    vecs[10] = '{1'b1, 3'd7, 32'h9,  32'h0,         1'b1};
    vecs[11] = '{1'b1, 3'd0, 32'd0,  32'h0,         1'b1};
    vecs[12] = '{1'b1, 3'd0, 32'd17, 32'h0,         1'b1};
    vecs[13] = '{1'b0, 3'd1, 32'h0,  32'h0000_1006, 1'b0};
    vecs[14] = '{1'b0, 3'd6, 32'h0,  32'h0,         1'b1};

    repeat (3) @(negedge clk);
    checkOutput("inRstValid", noc_out_valid, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rstValid", noc_out_valid, 1'b0);
    checkOutput("rstIrq", irq, 1'b0);
    checkOutput("rstInReady", noc_in_ready, 1'b1);
    checkOutput("rstAck", bus_ack, 1'b0);

    // Register map table
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i].we, vecs[i].regIdx, vecs[i].wdata, rd, er, dc);
      checkOutput($sformatf("vec%0d_err", i), er, vecs[i].expErr);
      if (!vecs[i].we) checkOutput($sformatf("vec%0d_data", i), rd, vecs[i].expData);
    end

    // Store-and-forward: nothing visible until the last flit is written
    noc_out_ready = 1'b1;
    busWrite("abcLen", 3'd0, 32'd3, 1'b0);
    checkOutput("abcHidden0", noc_out_valid, 1'b0);
    busWrite("abcA", 3'd0, 32'hA, 1'b0);
    checkOutput("abcHidden1", noc_out_valid, 1'b0);
    busWrite("abcB", 3'd0, 32'hB, 1'b0);
    checkOutput("abcHidden2", noc_out_valid, 1'b0);
    busWrite("abcC", 3'd0, 32'hC, 1'b0);
    checkOutput("abcValidA", noc_out_valid, 1'b1);
    checkOutput("abcFlitA", {noc_out_last, noc_out_flit}, {1'b0, 32'hA});
    @(negedge clk);
    checkOutput("abcFlitB", {noc_out_valid, noc_out_last, noc_out_flit[30:0]}, {1'b1, 1'b0, 31'hB});
    @(negedge clk);
    checkOutput("abcFlitC", {noc_out_valid, noc_out_last, noc_out_flit[30:0]}, {1'b1, 1'b1, 31'hC});
    @(negedge clk);
    checkOutput("abcDrained", noc_out_valid, 1'b0);

    // Full FIFO holds the next data write until a flit drains
    noc_out_ready = 1'b0;
    busWrite("stallLen", 3'd0, 32'd16, 1'b0);
    for (int i = 0; i < 16; i++) busWrite($sformatf("stallFill%0d", i), 3'd0, 32'h100 + i, 1'b0);
    busRead("stallStatus", 3'd1, 32'h0000_0002, 1'b0);
    busWrite("stall2Len", 3'd0, 32'd2, 1'b0);
    @(negedge clk);
    bus_addr = 32'h0; bus_we = 1'b1; bus_data_in = 32'h200; bus_en = 1'b1;
    acked = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus_ack) acked = 1;
    end
    checkOutput("stallHeld", acked, 1'b0);
    noc_out_ready = 1'b1;
    ackDelay = -1;
    for (int k = 1; k <= 40; k++) begin
      if (noc_out_valid) got.push_back({noc_out_last, noc_out_flit});
      @(negedge clk);
      if (bus_ack && bus_en) begin
        ackDelay = k;
        bus_en = 1'b0;
      end
    end
    checkOutput("stallAckDelay", 33'(ackDelay), 33'd2);
    checkOutput("stallStreamLen", 33'(got.size()), 33'd16);
    for (int i = 0; i < 16 && i < got.size(); i++)
      checkOutput($sformatf("stallFlit%0d", i), got[i], {(i == 15), 32'h100 + i});
    checkOutput("stallUncommittedHidden", noc_out_valid, 1'b0);
    doReset();

    // Ingress packet, interrupt and pop sequence
    injectFlit(32'h11, 1'b0);
    injectFlit(32'h22, 1'b1);
    busWrite("irqEnSet", 3'd2, 32'h1, 1'b0);
    @(negedge clk);
    checkOutput("irqHigh", irq, 1'b1);
    busRead("rxPkts1", 3'd3, 32'd1, 1'b0);
    busRead("recv11", 3'd0, 32'h11, 1'b0);
    busRead("recv22", 3'd0, 32'h22, 1'b0);
    checkOutput("irqStillHigh", irq, 1'b1);
    @(negedge clk);
    checkOutput("irqLow", irq, 1'b0);
    busRead("statusLastRd", 3'd1, 32'h0000_100E, 1'b0);
    busRead("recvEmpty", 3'd0, 32'h0, 1'b1);

    // Reset with one packet half drained and another half written
    noc_out_ready = 1'b0;
    busWrite("midLenA", 3'd0, 32'd4, 1'b0);
    for (int i = 0; i < 4; i++) busWrite("midA", 3'd0, 32'h300 + i, 1'b0);
    busWrite("midLenB", 3'd0, 32'd4, 1'b0);
    for (int i = 0; i < 2; i++) busWrite("midB", 3'd0, 32'h400 + i, 1'b0);
    injectFlit(32'h55, 1'b1);
    @(negedge clk);
    noc_out_ready = 1'b1;
    repeat (2) @(negedge clk);
    noc_out_ready = 1'b0;
    checkOutput("preRstValid", noc_out_valid, 1'b1);
    checkOutput("preRstFlit", noc_out_flit, 32'h302);
    checkOutput("preRstIrq", irq, 1'b1);
    rst = 1'b1;
    #1;
    checkOutput("asyncRstValid", noc_out_valid, 1'b0);
    checkOutput("asyncRstIrq", irq, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    busRead("postRstStatus", 3'd1, 32'h0000_1006, 1'b0);
    busRead("postRstRxPkts", 3'd3, 32'h0, 1'b0);
    busRead("postRstIrqEn", 3'd2, 32'h0, 1'b0);
    checkOutput("postRstInReady", noc_in_ready, 1'b1);

    // Randomized traffic: bus process, egress sink and ingress source in parallel
    fork
      begin : busProc
        logic [32:0] pkt[$];
        logic [31:0] d;
        int len;
        int choice;
        inEnt_t e;
        for (int op = 0; op < 60; op++) begin
          choice = $urandom_range(0, 9);
          if (choice < 4) begin
            len = $urandom_range(1, 6);
            busWrite("rndLen", 3'd0, 32'(len), 1'b0);
            pkt.delete();
            for (int j = 0; j < len; j++) begin
              d = $urandom();
              pkt.push_back({(j == len - 1), d});
              busWrite("rndSend", 3'd0, d, 1'b0);
            end
            foreach (pkt[j]) egQ.push_back(pkt[j]);
          end else if (choice < 5) begin
            d = ($urandom_range(0, 1) != 0) ? 32'd0 : 32'(SIZE + 1 + $urandom_range(0, 100));
            busWrite("rndBadLen", 3'd0, d, 1'b1);
          end else begin
            applyStimulus(1'b0, 3'd0, 32'h0, rd, er, dc);
            if (inQ.size() > 0 && inQ[0].land <= dc) begin
              e = inQ.pop_front();
              checkOutput("rndRecvData", {er, rd}, {1'b0, e.data});
            end else begin
              checkOutput("rndRecvEmpty", {er, rd}, {1'b1, 32'h0});
            end
          end
        end
        done = 1;
      end
      begin : egressSink
        logic [32:0] exp;
        forever begin
          @(negedge clk);
          #2;
          if (done) begin
            noc_out_ready = 1'b0;
            break;
          end
          noc_out_ready = ($urandom_range(0, 1) != 0);
          if (noc_out_valid) begin
            checkOutput("rndCommitted", (egQ.size() != 0), 1'b1);
            if (noc_out_ready && egQ.size() != 0) begin
              exp = egQ.pop_front();
              checkOutput("rndFlit", {noc_out_last, noc_out_flit}, exp);
            end
          end
        end
      end
      begin : ingressSource
        int remain;
        inEnt_t e;
        remain = 0;
        forever begin
          @(negedge clk);
          #2;
          if (done) begin
            noc_in_valid = 1'b0;
            break;
          end
          if (noc_in_ready && $urandom_range(0, 2) != 0) begin
            if (remain == 0) remain = $urandom_range(1, 4);
            e.data = $urandom();
            e.last = (remain == 1);
            e.land = cyc + 1;
            remain--;
            noc_in_flit  = e.data;
            noc_in_last  = e.last;
            noc_in_valid = 1'b1;
            inQ.push_back(e);
          end else begin
            noc_in_valid = 1'b0;
          end
        end
      end
    join

    // Drain whatever the model still expects on both sides
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      #2;
      noc_out_ready = 1'b1;
      if (noc_out_valid) begin
        checkOutput("drainCommitted", (egQ.size() != 0), 1'b1);
        if (egQ.size() != 0) checkOutput("drainFlit", {noc_out_last, noc_out_flit}, egQ.pop_front());
      end
    end
    checkOutput("drainEgModelEmpty", 33'(egQ.size()), 33'd0);
    checkOutput("drainEgValid", noc_out_valid, 1'b0);
    while (inQ.size() > 0) begin
      inEnt_t e;
      e = inQ.pop_front();
      busRead("drainRecv", 3'd0, e.data, 1'b0);
    end
    busRead("drainRecvEmpty", 3'd0, 32'h0, 1'b1);
    busRead("drainRxPkts", 3'd3, 32'h0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
